// File: rtl/vr_serial_pkg.sv
// Shared definitions for the dual-rail serial link: SIPO state encoding and symbol constants.
package vr_serial_pkg;

  typedef enum logic [1:0] {
    SIPO_IDLE    = 2'd0,
    SIPO_COLLECT = 2'd1,
    SIPO_STALL   = 2'd2
  } sipo_state_t;

  // Dual-rail encoding: exactly one rail high carries a bit; both-low and both-high are illegal.
  localparam logic [1:0] SYM_ONE   = 2'b01;
  localparam logic [1:0] SYM_ZERO  = 2'b10;
  localparam logic [1:0] SYM_IDLE0 = 2'b00;
  localparam logic [1:0] SYM_BAD   = 2'b11;

  function automatic logic sym_is_legal(input logic [1:0] sym);
    return (sym == SYM_ONE) || (sym == SYM_ZERO);
  endfunction

  function automatic logic [1:0] bit_to_sym(input logic b);
    return b ? SYM_ONE : SYM_ZERO;
  endfunction

endpackage

// File: rtl/dual_rail_dec.sv
// Combinational dual-rail symbol decoder: returns the carried bit and whether the symbol is legal.
module dual_rail_dec
  import vr_serial_pkg::*;
(
  input  logic [1:0] sym,
  output logic       sym_bit,
  output logic       sym_legal
);

  assign sym_bit   = sym[0];
  assign sym_legal = sym_is_legal(sym);

endmodule

// File: rtl/sipo_deser.sv
// Dual-rail serial-in parallel-out deserializer, LSB first, DATAWIDTH symbols per word.
// Optional framing/symbol checking is enabled by defining SIPO_FRAME_CHECK_EN.
module sipo_deser
  import vr_serial_pkg::*;
#(
  parameter int DATAWIDTH = 8
)
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 din_valid,
  output logic                 din_ready,
  input  logic [1:0]           din_data,
  input  logic                 din_last,
  output logic                 dout_valid,
  input  logic                 dout_ready,
  output logic [DATAWIDTH-1:0] dout_data,
  output logic                 err
);

  localparam int            CW       = $clog2(DATAWIDTH);
  localparam logic [CW-1:0] LAST_IDX = CW'(DATAWIDTH - 1);

  logic [CW-1:0]        cnt;
  logic [DATAWIDTH-2:0] shift_reg;
  sipo_state_t          state;
  sipo_state_t          state_nxt;
  logic                 sym_bit;
  logic                 sym_legal;
  logic                 at_last;
  logic                 din_fire;
  logic                 dout_fire;
  logic                 frame_bad;
  logic                 good_fire;
  logic                 word_load;

  dual_rail_dec u_dec (
    .sym       (din_data),
    .sym_bit   (sym_bit),
    .sym_legal (sym_legal)
  );

  // Only the final symbol can stall, and only while an earlier word is still unconsumed.
  assign at_last   = (cnt == LAST_IDX);
  assign din_ready = ~rst & (~at_last | ~dout_valid | dout_ready);
  assign din_fire  = din_valid & din_ready;
  assign dout_fire = dout_valid & dout_ready;

`ifdef SIPO_FRAME_CHECK_EN
  assign frame_bad = ~sym_legal | (din_last != at_last);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err <= 1'b0;
    end else begin
      err <= din_fire & frame_bad;
    end
  end
`else
  logic unused_frame_inputs;
  assign unused_frame_inputs = &{1'b0, sym_legal, din_last};
  assign frame_bad           = 1'b0;
  assign err                 = 1'b0;
`endif

  assign good_fire = din_fire & ~frame_bad;
  assign word_load = good_fire & at_last;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt       <= '0;
      shift_reg <= '0;
    end else if (din_fire) begin
      if (frame_bad | at_last) begin
        cnt <= '0;
      end else begin
        cnt            <= cnt + 1'b1;
        shift_reg[cnt] <= sym_bit;
      end
    end
  end

  // A new word loading in the same cycle as a consume keeps dout_valid high with no bubble.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dout_valid <= 1'b0;
      dout_data  <= '0;
    end else if (word_load) begin
      dout_valid <= 1'b1;
      dout_data  <= {sym_bit, shift_reg};
    end else if (dout_fire) begin
      dout_valid <= 1'b0;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      SIPO_IDLE: begin
        if (good_fire) state_nxt = SIPO_COLLECT;
      end
      SIPO_COLLECT: begin
        if (word_load)                           state_nxt = SIPO_IDLE;
        else if (at_last & din_valid & ~din_ready) state_nxt = SIPO_STALL;
      end
      SIPO_STALL: begin
        if (din_fire)        state_nxt = SIPO_IDLE;
        else if (~din_valid) state_nxt = SIPO_COLLECT;
      end
      default: state_nxt = SIPO_IDLE;
    endcase
    if (din_fire & frame_bad) state_nxt = SIPO_IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= SIPO_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

endmodule

// File: tb/tb_sipo_deser.sv
// Self-checking bench for sipo_deser: directed link scenarios plus randomized traffic against a frame-level model.
module tb_sipo_deser;
  import vr_serial_pkg::*;

  localparam int DW = 8;
`ifdef SIPO_FRAME_CHECK_EN
  localparam bit FRAME_CHECK = 1'b1;
`else
  localparam bit FRAME_CHECK = 1'b0;
`endif

  logic          clk        = 1'b0;
  logic          rst        = 1'b1;
  logic          din_valid  = 1'b0;
  logic          din_ready;
  logic [1:0]    din_data   = SYM_IDLE0;
  logic          din_last   = 1'b0;
  logic          dout_valid;
  logic          dout_ready = 1'b0;
  logic [DW-1:0] dout_data;
  logic          err;

  int total = 0;
  int bad   = 0;
  int ready_mode = 1;

  logic [DW-1:0] exp_q[$];
  int            pos       = 0;
  logic [DW-1:0] frame_acc = '0;
  bit            err_pend  = 1'b0;
  bit            acc_now   = 1'b0;

  always #5 clk = ~clk;

  sipo_deser #(.DATAWIDTH(DW)) dut (
    .clk        (clk),
    .rst        (rst),
    .din_valid  (din_valid),
    .din_ready  (din_ready),
    .din_data   (din_data),
    .din_last   (din_last),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .dout_data  (dout_data),
    .err        (err)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    if (observed !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h at t=%0t", tag, observed, expected, $time);
    end
  endtask

  // Frame-level model: words are queued when their last symbol is taken, popped when consumed.
  always @(negedge clk) begin
    bit exp_valid;
    bit exp_ready;
    bit sym_err;
    if (rst) begin
      checkOutput("rst_dout_valid", 32'(dout_valid), 32'd0);
      checkOutput("rst_din_ready", 32'(din_ready), 32'd0);
      checkOutput("rst_dout_data", 32'(dout_data), 32'd0);
      checkOutput("rst_err", 32'(err), 32'd0);
      exp_q.delete();
      pos       = 0;
      frame_acc = '0;
      err_pend  = 1'b0;
      acc_now   = 1'b0;
    end else begin
      exp_valid = (exp_q.size() != 0);
      exp_ready = !((pos == DW - 1) && exp_valid && !dout_ready);
      checkOutput("dout_valid", 32'(dout_valid), 32'(exp_valid));
      checkOutput("din_ready", 32'(din_ready), 32'(exp_ready));
      checkOutput("err", 32'(err), 32'(err_pend));
      if (exp_valid) checkOutput("dout_data", 32'(dout_data), 32'(exp_q[0]));
      err_pend = 1'b0;
      acc_now  = din_valid && exp_ready;
      if (exp_valid && dout_ready) void'(exp_q.pop_front());
      if (acc_now) begin
        sym_err = FRAME_CHECK && ((din_data == SYM_IDLE0) || (din_data == SYM_BAD) ||
                                  (din_last != (pos == DW - 1)));
        if (sym_err) begin
          pos       = 0;
          frame_acc = '0;
          err_pend  = 1'b1;
        end else begin
          frame_acc = frame_acc | (DW'(din_data[0]) << pos);
          if (pos == DW - 1) begin
            exp_q.push_back(frame_acc);
            pos       = 0;
            frame_acc = '0;
          end else begin
            pos++;
          end
        end
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       dout_ready = 1'b0;
        1:       dout_ready = 1'b1;
        default: dout_ready = ($urandom_range(0, 2) != 0);
      endcase
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Sends one frame; bad_pos injects an illegal symbol, last_pos places din_last, stop_after truncates.
  task automatic applyStimulus(input logic [DW-1:0] word, input int bad_pos, input int last_pos,
                               input int stop_after, input bit bubbles);
    bit done;
    for (int k = 0; k < DW; k++) begin
      if (k == stop_after) break;
      if (bubbles) begin
        int gap = $urandom_range(0, 2);
        repeat (gap) begin
          din_valid = 1'b0;
          din_data  = 2'($urandom);
          din_last  = 1'($urandom);
          @(posedge clk);
          #1;
          if (rst) begin
            din_valid = 1'b0;
            return;
          end
        end
      end
      din_valid = 1'b1;
      if (k == bad_pos) din_data = word[k] ? SYM_BAD : SYM_IDLE0;
      else              din_data = bit_to_sym(word[k]);
      din_last = (k == last_pos);
      done = 1'b0;
      for (int c = 0; c < 200 && !done; c++) begin
        @(posedge clk);
        #1;
        if (rst) begin
          din_valid = 1'b0;
          return;
        end
        if (acc_now) done = 1'b1;
      end
      checkOutput("din_accepted", 32'(done), 32'd1);
      if (!done) begin
        din_valid = 1'b0;
        return;
      end
      if (FRAME_CHECK && ((k == bad_pos) || ((k == last_pos) != (k == DW - 1)))) break;
    end
    din_valid = 1'b0;
    din_last  = 1'b0;
  endtask

  task automatic applyReset(input int cycles);
    @(posedge clk);
    #2;
    rst       = 1'b1;
    din_valid = 1'b0;
    repeat (cycles) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete, total=%0d bad=%0d", total, bad);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [DW-1:0] words[3];
    logic [DW-1:0] w;
    int bp;
    int lp;
    words[0] = 8'h12;
    words[1] = 8'h34;
    words[2] = 8'h56;

    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    $display("[TB] single word 0xA5");
    ready_mode = 1;
    idle(1);
    applyStimulus(8'hA5, -1, DW - 1, DW, 1'b0);
    idle(3);

    $display("[TB] back-to-back words");
    for (int i = 0; i < 3; i++) applyStimulus(words[i], -1, DW - 1, DW, 1'b0);
    idle(3);

    $display("[TB] output stall with overlapping collection");
    ready_mode = 0;
    idle(1);
    applyStimulus(8'h11, -1, DW - 1, DW, 1'b0);
    fork
      applyStimulus(8'h22, -1, DW - 1, DW, 1'b0);
      begin
        repeat (20) @(posedge clk);
        ready_mode = 1;
      end
    join
    idle(4);

    $display("[TB] symbol and framing errors");
    applyStimulus(8'h0F, 3, DW - 1, DW, 1'b0);
    applyStimulus(8'h5A, -1, 5, DW, 1'b0);
    applyStimulus(8'h3C, -1, DW - 1, DW, 1'b0);
    idle(4);

    $display("[TB] reset mid-frame and mid-stall");
    applyStimulus(8'h55, -1, DW - 1, 4, 1'b0);
    applyReset(2);
    ready_mode = 0;
    idle(1);
    applyStimulus(8'h81, -1, DW - 1, DW, 1'b0);
    fork
      applyStimulus(8'h42, -1, DW - 1, DW, 1'b0);
      begin
        repeat (DW + 4) @(posedge clk);
        applyReset(2);
      end
    join
    ready_mode = 1;
    idle(2);
    applyStimulus(8'hFF, -1, DW - 1, DW, 1'b0);
    idle(4);

    $display("[TB] randomized traffic");
    ready_mode = 2;
    for (int i = 0; i < 40; i++) begin
      w  = DW'($urandom);
      bp = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, DW - 1)) : -1;
      lp = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, DW)) : DW - 1;
      applyStimulus(w, bp, lp, DW, 1'b1);
    end

    ready_mode = 1;
    idle(6);
    checkOutput("drain_valid", 32'(dout_valid), 32'd0);
    checkOutput("drain_queue", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
